// File: rtl/hazard_scoreboard_id.sv
// rtl/hazard_scoreboard_id.sv - ID-stage destination tag scoreboard with load-use and HI/LO stall control
module hazard_scoreboard_id #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_RegWriteEn,
    input  logic [4:0]  id_writeRegister,
    input  logic        id_MemRead,
    input  logic        id_is_mdu,
    input  logic        id_reads_hilo,
    input  logic        flush,
    output logic        stall_ID,
    output logic        bubble_IDEX,
    output logic        RegWriteEn_EXMEM,
    output logic [4:0]  writeRegister_EXMEM,
    output logic        RegWriteEn_MEMWB,
    output logic [4:0]  writeRegister_MEMWB,
    output logic        mdu_busy,
    output logic [31:0] pending_regs
);

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic       wen;
        logic       load;
        logic       mdu;
        logic [4:0] dest;
    } slot_t;

    slot_t            s1;   // ID/EX
    slot_t            s2;   // EX/MEM
    slot_t            s3;   // MEM/WB
    slot_t            s1_next;
    logic [CNT_W-1:0] cnt;
    logic             issue;
    logic             rs_match;
    logic             rt_match;
    logic             load_use;
    logic             hilo_hazard;

    // Decide what enters ID/EX: the ID instruction when it issues, else a bubble.
    // A write to $0 is dropped here so no later stage ever sees it as pending.
    always_comb begin
        s1_next = '0;
        if (issue) begin
            s1_next.wen  = id_RegWriteEn && (id_writeRegister != 5'd0);
            s1_next.load = id_MemRead;
            s1_next.mdu  = id_is_mdu;
            s1_next.dest = id_writeRegister;
        end
    end

    // Hazard detection: only a load still in ID/EX cannot be forwarded in time,
    // and HI/LO consumers must wait out the MDU including the op sitting in ID/EX.
    always_comb begin
        rs_match    = id_uses_rs && (s1.dest == id_rs);
        rt_match    = id_uses_rt && (s1.dest == id_rt);
        load_use    = s1.wen && s1.load && (rs_match || rt_match);
        hilo_hazard = ((cnt != '0) || s1.mdu) && (id_reads_hilo || id_is_mdu);
        stall_ID    = id_valid && !flush && (load_use || hilo_hazard);
        bubble_IDEX = stall_ID || flush;
        issue       = id_valid && !flush && !stall_ID;
    end

    // Slot pipeline advances every cycle; stalls only change what enters S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= s1_next;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // MDU busy counter: reload as the op leaves ID/EX, then count down to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (s1.mdu) begin
            cnt <= CNT_W'(MDU_LATENCY);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Exported forwarding tags and status come straight from registers.
    always_comb begin
        RegWriteEn_EXMEM    = s2.wen;
        writeRegister_EXMEM = s2.dest;
        RegWriteEn_MEMWB    = s3.wen;
        writeRegister_MEMWB = s3.dest;
        mdu_busy            = (cnt != '0);
    end

    // Per-register pending-write map; $0 is never pending.
    always_comb begin
        pending_regs = '0;
        for (int r = 1; r < 32; r++) begin
            pending_regs[r] = (s1.wen && (s1.dest == 5'(r))) ||
                              (s2.wen && (s2.dest == 5'(r))) ||
                              (s3.wen && (s3.dest == 5'(r)));
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_id.sv
// tb/tb_hazard_scoreboard_id.sv - randomized scoreboard bench for hazard_scoreboard_id
module tb_hazard_scoreboard_id;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_RegWriteEn;
    logic [4:0]  id_writeRegister;
    logic        id_MemRead;
    logic        id_is_mdu;
    logic        id_reads_hilo;
    logic        flush;
    logic        stall_ID;
    logic        bubble_IDEX;
    logic        RegWriteEn_EXMEM;
    logic [4:0]  writeRegister_EXMEM;
    logic        RegWriteEn_MEMWB;
    logic [4:0]  writeRegister_MEMWB;
    logic        mdu_busy;
    logic [31:0] pending_regs;

    hazard_scoreboard_id #(.MDU_LATENCY(LAT), .CNT_W(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_valid            (id_valid),
        .id_rs               (id_rs),
        .id_rt               (id_rt),
        .id_uses_rs          (id_uses_rs),
        .id_uses_rt          (id_uses_rt),
        .id_RegWriteEn       (id_RegWriteEn),
        .id_writeRegister    (id_writeRegister),
        .id_MemRead          (id_MemRead),
        .id_is_mdu           (id_is_mdu),
        .id_reads_hilo       (id_reads_hilo),
        .flush               (flush),
        .stall_ID            (stall_ID),
        .bubble_IDEX         (bubble_IDEX),
        .RegWriteEn_EXMEM    (RegWriteEn_EXMEM),
        .writeRegister_EXMEM (writeRegister_EXMEM),
        .RegWriteEn_MEMWB    (RegWriteEn_MEMWB),
        .writeRegister_MEMWB (writeRegister_MEMWB),
        .mdu_busy            (mdu_busy),
        .pending_regs        (pending_regs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       we;
        logic [4:0] wr;
        logic       mr;
        logic       mdu;
        logic       hilo;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       bubble;
        logic       we2;
        logic [4:0] wr2;
        logic       we3;
        logic [4:0] wr3;
        logic       busy;
        logic [31:0] pend;
    } exp_t;

    // Reference model: the last three instructions that entered the pipe
    // (index 0 = newest) and the number of edges since the last MDU op entered.
    stim_t hist [3];
    logic  hist_ok [3];
    int    mdu_age;
    stim_t cur;
    exp_t  exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit writes(int i, int r);
        return hist_ok[i] && hist[i].we && (hist[i].wr != 0) && (int'(hist[i].wr) == r);
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        bit   lu;
        bit   hz;
        lu = 0;
        if (hist_ok[0] && hist[0].mr && hist[0].we && hist[0].wr != 0) begin
            if (s.urs && s.rs == hist[0].wr) lu = 1;
            if (s.urt && s.rt == hist[0].wr) lu = 1;
        end
        // MDU still occupied from entering ID/EX through LAT cycles after leaving it
        hz = (mdu_age <= LAT) && (s.hilo || s.mdu);
        e.stall  = s.v && !s.fl && (lu || hz);
        e.bubble = e.stall || s.fl;
        e.we2    = hist_ok[1] && hist[1].we && hist[1].wr != 0;
        e.wr2    = hist_ok[1] ? hist[1].wr : 5'd0;
        e.we3    = hist_ok[2] && hist[2].we && hist[2].wr != 0;
        e.wr3    = hist_ok[2] ? hist[2].wr : 5'd0;
        e.busy   = (mdu_age >= 1) && (mdu_age <= LAT);
        e.pend   = '0;
        for (int r = 1; r < 32; r++)
            e.pend[r] = writes(0, r) || writes(1, r) || writes(2, r);
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i]    = nop();
            hist_ok[i] = 0;
        end
        mdu_age = 1000;
    endfunction

    function automatic void model_edge(stim_t s);
        exp_t e;
        bit   enter;
        e     = predict(s);
        enter = s.v && !s.fl && !e.stall;
        hist[2]    = hist[1];
        hist_ok[2] = hist_ok[1];
        hist[1]    = hist[0];
        hist_ok[1] = hist_ok[0];
        hist[0]    = s;
        hist_ok[0] = enter;
        if (enter && s.mdu) mdu_age = 0;
        else if (mdu_age < 1000) mdu_age++;
    endfunction

    task automatic drive(stim_t s);
        id_valid         = s.v;
        id_rs            = s.rs;
        id_rt            = s.rt;
        id_uses_rs       = s.urs;
        id_uses_rt       = s.urt;
        id_RegWriteEn    = s.we;
        id_writeRegister = s.wr;
        id_MemRead       = s.mr;
        id_is_mdu        = s.mdu;
        id_reads_hilo    = s.hilo;
        flush            = s.fl;
    endtask

    // One cycle: model follows the edge, then the new ID contents are driven and
    // their expected response queued for the monitor.
    task automatic step(stim_t s);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(cur);
        #1;
        drive(s);
        cur = s;
        exp_q.push_back(predict(s));
    endtask

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    // Monitor: pops one expectation per cycle, mid-cycle away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall_ID", 32'(stall_ID), 32'(e.stall));
            check("bubble_IDEX", 32'(bubble_IDEX), 32'(e.bubble));
            check("RegWriteEn_EXMEM", 32'(RegWriteEn_EXMEM), 32'(e.we2));
            check("writeRegister_EXMEM", 32'(writeRegister_EXMEM), 32'(e.wr2));
            check("RegWriteEn_MEMWB", 32'(RegWriteEn_MEMWB), 32'(e.we3));
            check("writeRegister_MEMWB", 32'(writeRegister_MEMWB), 32'(e.wr3));
            check("mdu_busy", 32'(mdu_busy), 32'(e.busy));
            check("pending_regs", pending_regs, e.pend);
        end
    end

    function automatic stim_t alu(int d, int a, int b);
        stim_t s;
        s = nop();
        s.v = 1; s.we = 1; s.wr = 5'(d);
        s.rs = 5'(a); s.rt = 5'(b); s.urs = 1; s.urt = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.v    = ($urandom_range(9) != 0);
        s.rs   = 5'($urandom_range(7));
        s.rt   = 5'($urandom_range(7));
        s.urs  = 1'($urandom_range(1));
        s.urt  = 1'($urandom_range(1));
        s.we   = ($urandom_range(3) != 0);
        s.wr   = 5'($urandom_range(7));
        s.mr   = ($urandom_range(2) == 0);
        s.mdu  = ($urandom_range(19) == 0);
        s.hilo = ($urandom_range(11) == 0);
        s.fl   = ($urandom_range(11) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        rst = 1'b1;
        cur = nop();
        drive(cur);
        model_reset();
        exp_q.push_back(predict(cur));
        @(posedge clk);
        #1 rst = 1'b0;

        // load-use: lw $5 then add $6,$5,$7 held while stalled
        s = alu(5, 1, 0); s.urt = 0; s.mr = 1;
        step(s);
        step(alu(6, 5, 7));
        step(alu(6, 5, 7));
        step(nop());
        // load to $0 with a consumer reading $0
        s = alu(0, 1, 0); s.mr = 1;
        step(s);
        step(alu(2, 0, 0));
        // Rs == Rt == load destination
        s = alu(8, 1, 0); s.mr = 1;
        step(s);
        step(alu(9, 8, 8));
        step(alu(9, 8, 8));
        // tag pipeline
        step(alu(3, 1, 2));
        step(alu(4, 1, 2));
        step(alu(9, 1, 2));
        step(nop());
        step(nop());
        // mult then mflo held in ID until released
        s = nop(); s.v = 1; s.mdu = 1; s.urs = 1; s.urt = 1; s.rs = 1; s.rt = 2;
        step(s);
        s = alu(10, 0, 0); s.urs = 0; s.urt = 0; s.hilo = 1;
        repeat (7) step(s);
        // flush together with a load-use match
        s = alu(11, 1, 0); s.mr = 1;
        step(s);
        s = alu(12, 11, 11); s.fl = 1;
        step(s);
        step(nop());

        // randomized traffic; stalled instructions are usually held in ID
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() > 0 && exp_q[$].stall && $urandom_range(3) != 0) s = cur;
            else s = rand_stim();
            step(s);
        end

        // async reset during an MDU stall
        step(alu(13, 1, 2));
        s = nop(); s.v = 1; s.mdu = 1;
        step(s);
        s = alu(14, 0, 0); s.urs = 0; s.urt = 0; s.hilo = 1;
        step(s);
        step(s);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_mdu_busy", 32'(mdu_busy), 32'd0);
        check("async_rst_stall_ID", 32'(stall_ID), 32'd0);
        check("async_rst_pending", pending_regs, 32'd0);
        check("async_rst_tag_EXMEM", 32'(RegWriteEn_EXMEM), 32'd0);
        step(s);
        rst = 1'b0;
        repeat (6) step(s);
        step(nop());
        step(nop());
        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
